add_bist_ctrl: RTL and testbench

ADD_BIST_CTRL -- requirements
Module: add_bist_ctrl

---
 rtl/add_bist_ctrl.sv | 110 +++++++++++
 tb/tb_add_bist_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/add_bist_ctrl.sv
// rtl/add_bist_ctrl.sv - adder self-test sweep controller: 16 operand vectors, saturating mismatch count.
// Optional first-failure capture (fail_vld/fail_vec) is built when ADD_BIST_CAPTURE_EN is defined.
module add_bist_ctrl #(
    parameter int ERR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ok_add,
    output logic [1:0]       in0_add,
    output logic [1:0]       in1_add,
    output logic             sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef ADD_BIST_CAPTURE_EN
    output logic             fail_vld,
    output logic [3:0]       fail_vec,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        sel       = 1'b0;
        done      = 1'b0;
        in0_add   = 2'd0;
        in1_add   = 2'd0;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy               = 1'b1;
                sel                = 1'b1;
                {in0_add, in1_add} = idx;
                if (abort)            state_nxt = S_IDLE;
                else if (idx == 4'hF) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The sample taken on the edge that ends a vector is dropped if abort is high on that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= 4'd0;
            err_cnt  <= '0;
            pass     <= 1'b0;
`ifdef ADD_BIST_CAPTURE_EN
            fail_vld <= 1'b0;
            fail_vec <= 4'd0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx      <= 4'd0;
                        err_cnt  <= '0;
                        pass     <= 1'b0;
`ifdef ADD_BIST_CAPTURE_EN
                        fail_vld <= 1'b0;
                        fail_vec <= 4'd0;
`endif
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                        if (!ok_add && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                        if (idx == 4'hF) pass <= (err_cnt == '0) && ok_add;
`ifdef ADD_BIST_CAPTURE_EN
                        if (!ok_add && !fail_vld) begin
                            fail_vld <= 1'b1;
                            fail_vec <= idx;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (abort) pass <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_bist_ctrl.sv
// tb/tb_add_bist_ctrl.sv - directed and random sweeps of add_bist_ctrl (ERR_W=5 and ERR_W=3) against a mask-based model.
module tb_add_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort;
    logic [15:0] okmask;
    logic [1:0]  a_in0, a_in1, b_in0, b_in1;
    logic        a_sel, a_busy, a_done, a_pass;
    logic        b_sel, b_busy, b_done, b_pass;
    logic [4:0]  a_err;
    logic [2:0]  b_err;
    logic        ok_a, ok_b;
`ifdef ADD_BIST_CAPTURE_EN
    logic        a_fvld, b_fvld;
    logic [3:0]  a_fvec, b_fvec;
`endif

    // Mock datapath: mask bit per operand vector says whether the adder agrees with the ROM.
    assign ok_a = okmask[{a_in0, a_in1}];
    assign ok_b = okmask[{b_in0, b_in1}];

    add_bist_ctrl #(.ERR_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ok_add(ok_a),
        .in0_add(a_in0), .in1_add(a_in1), .sel(a_sel), .busy(a_busy), .done(a_done),
        .pass(a_pass),
`ifdef ADD_BIST_CAPTURE_EN
        .fail_vld(a_fvld), .fail_vec(a_fvec),
`endif
        .err_cnt(a_err)
    );

    add_bist_ctrl #(.ERR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ok_add(ok_b),
        .in0_add(b_in0), .in1_add(b_in1), .sel(b_sel), .busy(b_busy), .done(b_done),
        .pass(b_pass),
`ifdef ADD_BIST_CAPTURE_EN
        .fail_vld(b_fvld), .fail_vec(b_fvec),
`endif
        .err_cnt(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int zeros_below(input logic [15:0] m, input int n);
        int z = 0;
        for (int i = 0; i < n; i++) if (!m[i]) z++;
        return z;
    endfunction

    function automatic int clamp(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk_idle(input string tag, input int ea, input int eb, input int epass);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_sel"}, a_sel, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_ops"}, {a_in0, a_in1}, 0);
        chk({tag, "_err_a"}, a_err, ea);
        chk({tag, "_err_b"}, b_err, eb);
        chk({tag, "_pass_a"}, a_pass, epass);
        chk({tag, "_pass_b"}, b_pass, epass);
    endtask

    // One sweep; abort_at 0..15 aborts on that vector, 16 aborts in the done cycle;
    // start_at raises start during that vector; rst_at pulls reset during that vector.
    task automatic sweep(input string tag, input logic [15:0] m, input int abort_at,
                         input int start_at, input int rst_at);
        int z;
        int first;
        okmask = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int v = 0; v < 16; v++) begin
            z = zeros_below(m, v);
            chk({tag, "_run_busy"}, a_busy, 1);
            chk({tag, "_run_sel"}, a_sel, 1);
            chk({tag, "_run_ops"}, {a_in0, a_in1}, v);
            chk({tag, "_run_done"}, a_done | b_done, 0);
            chk({tag, "_run_err_a"}, a_err, clamp(z, 31));
            chk({tag, "_run_err_b"}, b_err, clamp(z, 7));
            if (v == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_idle({tag, "_abort"}, clamp(z, 31), clamp(z, 7), 0);
                @(negedge clk);
                chk_idle({tag, "_abort_hold"}, clamp(z, 31), clamp(z, 7), 0);
                return;
            end
            if (v == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_idle({tag, "_rst"}, 0, 0, 0);
`ifdef ADD_BIST_CAPTURE_EN
                chk({tag, "_rst_fvld"}, a_fvld, 0);
                chk({tag, "_rst_fvec"}, a_fvec, 0);
`endif
                @(negedge clk);
                chk({tag, "_rst_nodone"}, a_done | b_done, 0);
                return;
            end
            start = (v == start_at);
            @(negedge clk);
            start = 1'b0;
        end
        z = zeros_below(m, 16);
        chk({tag, "_done_a"}, a_done, 1);
        chk({tag, "_done_b"}, b_done, 1);
        chk({tag, "_done_busy"}, a_busy, 0);
        chk({tag, "_done_sel"}, a_sel, 0);
        chk({tag, "_done_ops"}, {a_in0, a_in1}, 0);
        chk({tag, "_done_pass"}, a_pass, (z == 0) ? 1 : 0);
        if (abort_at == 16) abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle({tag, "_end"}, clamp(z, 31), clamp(z, 7),
                 (z == 0 && abort_at != 16) ? 1 : 0);
`ifdef ADD_BIST_CAPTURE_EN
        first = 0;
        for (int i = 15; i >= 0; i--) if (!m[i]) first = i;
        chk({tag, "_fvld"}, a_fvld, (z != 0) ? 1 : 0);
        chk({tag, "_fvec"}, a_fvec, first);
        chk({tag, "_fvld_b"}, b_fvld, (z != 0) ? 1 : 0);
`else
        first = 0;
`endif
        @(negedge clk);
        chk({tag, "_stable_err"}, a_err, clamp(z, 31));
        chk({tag, "_stable_done"}, a_done, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        okmask = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_idle("reset", 0, 0, 0);

        sweep("allok", 16'hFFFF, -1, -1, -1);

        // start together with abort in IDLE is refused; results from the passing sweep stay put
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk_idle("start_abort", 0, 0, 1);
        @(negedge clk);
        chk_idle("start_abort2", 0, 0, 1);

        sweep("v6v11", ~16'h0840, -1, -1, -1);
        sweep("allbad", 16'h0000, -1, -1, -1);
        sweep("abort5", 16'h5A5A, 5, -1, -1);
        sweep("start9", 16'h7BDE, -1, 9, -1);
        sweep("abortdone", 16'hFFFF, 16, -1, -1);
        sweep("rst8", 16'h00F0, -1, -1, 8);

        for (int r = 0; r < 6; r++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (r == 0) m = m | 16'hFF00;
            sweep("rand", m, -1, -1, -1);
        end
        sweep("rand_abort", 16'($urandom), int'($urandom_range(0, 15)), -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
